// File: rtl/sw_bcd_encoder.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock) feeding the 7-seg driver.
// Optional macro AUTO_RELOAD_EN: ignore load and re-convert value_in continuously whenever idle.
module sw_bcd_encoder #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [IN_W-1:0]       value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [DIGITS*4-1:0]   digits
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IN_W-1:0]  bin_q;
    logic [IN_W-1:0]  bin_d;
    logic [BCD_W-1:0] scratch_q;
    logic [BCD_W-1:0] scratch_d;
    logic [BCD_W-1:0] scratch_adj_c;
    logic [BCD_W-1:0] digits_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             start_c;

`ifdef AUTO_RELOAD_EN
    logic unused_load;
    assign unused_load = load;
    assign start_c     = 1'b1;
`else
    assign start_c     = load;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift {scratch, bin} left.
    // Anything shifted out of the top digit is dropped, giving the result mod 10^DIGITS.
    always_comb begin
        scratch_adj_c = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, bin_d} = {scratch_adj_c[BCD_W-2:0], bin_q, 1'b0};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            digits_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_c) begin
                        bin_q     <= value_in;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(IN_W);
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q     <= bin_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Publish the finished result in one step so the display never sees partial digits
                    digits_q <= scratch_q;
                    done_q   <= 1'b1;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign valid  = valid_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_sw_bcd_encoder.sv
// Self-checking bench for sw_bcd_encoder: arithmetic reference model plus directed literal checks.
module tb_sw_bcd_encoder;

    localparam int unsigned IN_W   = 16;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BCD_W  = DIGITS * 4;
    localparam int          LAT    = IN_W + 1;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             CLK      = 1'b0;
    logic             RST      = 1'b1;
    logic             load     = 1'b0;
    logic [IN_W-1:0]  value_in = '0;
    logic             busy;
    logic             done;
    logic             valid;
    logic [BCD_W-1:0] digits;

    int n_checks = 0;
    int n_fail   = 0;

    sw_bcd_encoder #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .digits   (digits)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by repeated division; truncation to DIGITS gives mod 10^DIGITS.
    function automatic logic [BCD_W-1:0] to_bcd(input longint unsigned v);
        logic [BCD_W-1:0] r;
        longint unsigned  x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Timeline model: a captured value appears LAT edges after its start edge.
    bit               m_active = 1'b0;
    int               m_age    = 0;
    longint unsigned  m_val    = 0;
    logic [BCD_W-1:0] m_digits = '0;
    bit               m_done   = 1'b0;
    bit               m_valid  = 1'b0;
    bit               chk_en   = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_active = 1'b0;
            m_age    = 0;
            m_digits = '0;
            m_done   = 1'b0;
            m_valid  = 1'b0;
            chk_en   = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == LAT) begin
                    m_digits = to_bcd(m_val);
                    m_done   = 1'b1;
                    m_valid  = 1'b1;
                    m_active = 1'b0;
                end
            end else if (AUTO || load) begin
                m_active = 1'b1;
                m_age    = 0;
                m_val    = longint'(value_in);
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_busy",   64'(busy),   64'(m_active));
            check("model_done",   64'(done),   64'(m_done));
            check("model_valid",  64'(valid),  64'(m_valid));
            check("model_digits", 64'(digits), 64'(m_digits));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called just after the start edge; returns edges until done and busy-high cycles seen.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            tick();
            edges++;
        end
    endtask

    task automatic run_conv(input logic [IN_W-1:0] v, input logic [BCD_W-1:0] exp, input string nm);
        int edges;
        int busy_cyc;
        value_in = v;
        load     = 1'b1;
        tick();
        load = 1'b0;
        wait_done(edges, busy_cyc);
        check({nm, "_latency"}, 64'(edges), 64'(LAT));
        check({nm, "_busy_cycles"}, 64'(busy_cyc), 64'(LAT));
        check({nm, "_digits"}, 64'(digits), 64'(exp));
        check({nm, "_valid"}, 64'(valid), 64'd1);
        tick();
        check({nm, "_done_one_cycle"}, 64'(done), 64'd0);
        check({nm, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [IN_W-1:0]  vec_in  [7] = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd1000, 16'd50000, 16'd59999};
    logic [BCD_W-1:0] vec_exp [7] = '{32'h9, 32'h10, 32'h99, 32'h100, 32'h1000, 32'h50000, 32'h59999};

    initial begin
        int edges;
        int busy_cyc;
        int n_done;
        int waited;

        RST      = 1'b1;
        value_in = AUTO ? 16'd9999 : 16'd0;
        tick();
        tick();
        check("reset_digits", 64'(digits), 64'd0);
        check("reset_valid",  64'(valid),  64'd0);
        check("reset_busy",   64'(busy),   64'd0);
        check("reset_done",   64'(done),   64'd0);
        RST = 1'b0;

        if (AUTO) begin
            load   = 1'b0;
            waited = 0;
            while (digits !== 32'h00009999 && waited < 60) begin
                tick();
                waited++;
            end
            check("auto_first_9999", 64'(digits), 64'h00009999);
            check("auto_valid", 64'(valid), 64'd1);
            value_in = 16'd10000;
            waited   = 0;
            while (digits !== 32'h00010000 && waited < 2 * (IN_W + 2)) begin
                tick();
                waited++;
            end
            check("auto_tracks_10000", 64'(digits), 64'h00010000);
            check("auto_within_bound", 64'(waited <= 2 * (IN_W + 2)), 64'd1);
            for (int i = 0; i < 40; i++) tick();
            check("auto_steady", 64'(digits), 64'h00010000);
        end else begin
            tick();
            check("idle_busy",  64'(busy),  64'd0);
            check("idle_valid", 64'(valid), 64'd0);

            run_conv(16'd0,     32'h00000000, "zero");
            run_conv(16'd1234,  32'h00001234, "v1234");
            run_conv(16'hFFFF,  32'h00065535, "max");
            for (int i = 0; i < 7; i++) run_conv(vec_in[i], vec_exp[i], "vec");

            // Result held through a conversion; in-flight input change and load ignored
            run_conv(16'd42, 32'h00000042, "v42");
            value_in = 16'd9999;
            load     = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            value_in = 16'd7;
            check("hold_mid_t4", 64'(digits), 64'h00000042);
            for (int i = 0; i < 3; i++) tick();
            load = 1'b1;
            tick();
            load = 1'b0;
            check("hold_mid_t8", 64'(digits), 64'h00000042);
            check("busy_mid_t8", 64'(busy), 64'd1);
            wait_done(edges, busy_cyc);
            check("v9999_edges_from_t8", 64'(edges), 64'd9);
            check("v9999_digits", 64'(digits), 64'h00009999);
            n_done = 0;
            for (int i = 0; i < 25; i++) begin
                tick();
                if (done) n_done++;
            end
            check("no_extra_done", 64'(n_done), 64'd0);
            check("v9999_held", 64'(digits), 64'h00009999);

            // Reset mid-conversion
            value_in = 16'd500;
            load     = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 9; i++) tick();
            RST = 1'b1;
            tick();
            check("midrst_digits", 64'(digits), 64'd0);
            check("midrst_valid",  64'(valid),  64'd0);
            check("midrst_busy",   64'(busy),   64'd0);
            check("midrst_done",   64'(done),   64'd0);
            RST = 1'b0;
            tick();
            check("midrst_stays_idle", 64'(busy), 64'd0);
            run_conv(16'd500, 32'h00000500, "v500");

            // Load held high: back-to-back conversions every IN_W+2 edges
            value_in = 16'd321;
            load     = 1'b1;
            n_done   = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (done) n_done++;
            end
            load = 1'b0;
            check("b2b_done_count", 64'(n_done), 64'd2);
            for (int i = 0; i < 20; i++) tick();
            check("b2b_digits", 64'(digits), 64'h00000321);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
